// File: rtl/des_key_schedule.sv
// des_key_schedule
//   Sequential DES key-schedule generator. A single rotating C/D register pair
//   produces the 16 round subkeys, one per valid/ready handshake. They come out
//   in encrypt order (K1..K16) or decrypt order (K16..K1).
//
//   Optional build macro: DES_KEY_PARITY_CHECK_EN
//     Defined   : each key byte must have odd parity. A bad key sets key_err,
//                 generates no schedule and pulses done.
//     Undefined : parity bits are ignored and key_err is tied 0.
//
//   Ports
//     clk          rising-edge clock
//     rst_n        asynchronous active-low reset
//     start        request schedule generation (sampled only in IDLE)
//     key[63:0]    DES key, bit 63 = DES bit 1 (sampled on accepted start)
//     decrypt      0 = K1..K16, 1 = K16..K1 (sampled on accepted start)
//     subkey[47:0] PC-2(C,D), bit 47 = PC-2 bit 1
//     subkey_valid subkey is valid (GEN state)
//     subkey_ready consumer accepts subkey this cycle
//     round_idx    0..15, emission-order index of the current subkey
//     busy         high while the schedule is being emitted
//     done         one-cycle pulse after the 16th subkey is accepted
//     key_err      key parity failure flag
module des_key_schedule (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [63:0] key,
   input  logic        decrypt,
   output logic [47:0] subkey,
   output logic        subkey_valid,
   input  logic        subkey_ready,
   output logic [3:0]  round_idx,
   output logic        busy,
   output logic        done,
   output logic        key_err
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_GEN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // Bit n set = round n+1 rotates by 2 (shift table 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1).
   localparam logic [15:0] SHIFT2 = 16'h7EFC;

   localparam int unsigned PC1_T [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

   localparam int unsigned PC2_T [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

   function automatic logic [55:0] pc1(input logic [63:0] k);
      logic [55:0] r;
      r = '0;
      for (int unsigned i = 0; i < 56; i++) r[55-i] = k[64-PC1_T[i]];
      return r;
   endfunction

   function automatic logic [47:0] pc2(input logic [55:0] cd);
      logic [47:0] r;
      r = '0;
      for (int unsigned i = 0; i < 48; i++) r[47-i] = cd[56-PC2_T[i]];
      return r;
   endfunction

   function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
      return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
   endfunction

   function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
      return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
   endfunction

   logic [1:0]  state_q, state_d;
   logic [27:0] c_q, c_d;
   logic [27:0] d_q, d_d;
   logic [3:0]  round_q, round_d;
   logic        dec_q, dec_d;
   logic [55:0] cd_load;
   logic        step_two;

`ifdef DES_KEY_PARITY_CHECK_EN
   logic        err_q, err_d;
   logic        par_bad;

   always_comb begin
      par_bad = 1'b0;
      for (int unsigned b = 0; b < 8; b++) begin
         if (!(^key[8*b +: 8])) par_bad = 1'b1;
      end
   end
`endif

   assign cd_load = pc1(key);

   always_comb begin
      state_d  = state_q;
      c_d      = c_q;
      d_d      = d_q;
      round_d  = round_q;
      dec_d    = dec_q;
      step_two = 1'b0;
`ifdef DES_KEY_PARITY_CHECK_EN
      err_d    = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               dec_d   = decrypt;
               round_d = '0;
`ifdef DES_KEY_PARITY_CHECK_EN
               err_d   = par_bad;
               if (par_bad) begin
                  state_d = S_DONE;
               end else
`endif
               begin
                  state_d = S_GEN;
                  // Decrypt starts from CD16, which equals CD0, so no load rotation.
                  if (decrypt) begin
                     c_d = cd_load[55:28];
                     d_d = cd_load[27:0];
                  end else begin
                     c_d = rotl(cd_load[55:28], SHIFT2[0]);
                     d_d = rotl(cd_load[27:0],  SHIFT2[0]);
                  end
               end
            end
         end
         S_GEN: begin
            if (subkey_ready) begin
               if (round_q == 4'd15) begin
                  state_d = S_DONE;
               end else begin
                  round_d = round_q + 4'd1;
                  // Encrypt steps forward by s(n+1); decrypt steps back by s(16-n).
                  if (dec_q) begin
                     step_two = SHIFT2[4'd15 - round_q];
                     c_d      = rotr(c_q, step_two);
                     d_d      = rotr(d_q, step_two);
                  end else begin
                     step_two = SHIFT2[round_q + 4'd1];
                     c_d      = rotl(c_q, step_two);
                     d_d      = rotl(d_q, step_two);
                  end
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         c_q     <= '0;
         d_q     <= '0;
         round_q <= '0;
         dec_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         c_q     <= c_d;
         d_q     <= d_d;
         round_q <= round_d;
         dec_q   <= dec_d;
      end
   end

`ifdef DES_KEY_PARITY_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= err_d;
   end
   assign key_err = err_q;
`else
   assign key_err = 1'b0;
`endif

   assign subkey       = pc2({c_q, d_q});
   assign subkey_valid = (state_q == S_GEN);
   assign busy         = (state_q == S_GEN);
   assign done         = (state_q == S_DONE);
   assign round_idx    = round_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// tb_des_key_schedule
//   Self-checking bench for des_key_schedule. The reference model computes each
//   subkey directly from PC-1, the cumulative shift count for that round and
//   PC-2. Published DES example subkeys are checked from a vector table.
module tb_des_key_schedule;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [63:0] key;
   logic        decrypt;
   logic [47:0] subkey;
   logic        subkey_valid;
   logic        subkey_ready;
   logic [3:0]  round_idx;
   logic        busy;
   logic        done;
   logic        key_err;

   des_key_schedule dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .key          (key),
      .decrypt      (decrypt),
      .subkey       (subkey),
      .subkey_valid (subkey_valid),
      .subkey_ready (subkey_ready),
      .round_idx    (round_idx),
      .busy         (busy),
      .done         (done),
      .key_err      (key_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
   localparam logic [63:0] KEY_B = 64'h0E329232EA6D0D73;

   int unsigned SHIFTS [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
   int unsigned PC1 [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
   int unsigned PC2 [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

   logic [47:0] got [16];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [27:0] rot28(input logic [27:0] x, input int unsigned r);
      logic [55:0] cc;
      cc = {x, x};
      return cc[55 - r -: 28];
   endfunction

   // Subkey emitted at position e: round n = e+1 (encrypt) or 16-e (decrypt).
   // Kn = PC-2 of CD0 rotated left by the sum of s1..sn.
   function automatic logic [47:0] ref_subkey(input logic [63:0] k, input logic dec,
                                              input int unsigned e);
      int unsigned n, cum;
      logic [55:0] cd;
      logic [27:0] c, d;
      logic [47:0] r;
      n   = dec ? 16 - e : e + 1;
      cum = 0;
      for (int unsigned i = 0; i < n; i++) cum += SHIFTS[i];
      cum = cum % 28;
      for (int unsigned i = 0; i < 56; i++) cd[55-i] = k[64-PC1[i]];
      c  = rot28(cd[55:28], cum);
      d  = rot28(cd[27:0], cum);
      cd = {c, d};
      for (int unsigned i = 0; i < 48; i++) r[47-i] = cd[56-PC2[i]];
      return r;
   endfunction

   function automatic logic [63:0] fix_parity(input logic [63:0] k);
      logic [63:0] r;
      r = k;
      for (int b = 0; b < 8; b++) if (!(^r[8*b +: 8])) r[8*b] = ~r[8*b];
      return r;
   endfunction

   // mode 0: ready always 1; 1: ready pattern 1,0,0,1; 2: random ready.
   // inject: pulse start with another key while round 5 is on the output.
   task automatic run_sched(input logic [63:0] k, input logic dec, input int mode,
                            input bit inject);
      int    hs, cyc;
      bit    rdy, injected;
      logic [47:0] prev_sk;
      logic [3:0]  prev_idx;
      bit    prev_rdy;
      key = k; decrypt = dec; start = 1'b1; subkey_ready = 1'b0;
      tick();
      start = 1'b0;
      key = {$urandom, $urandom};
      decrypt = ~dec;
      hs = 0; cyc = 0; injected = 0; prev_rdy = 1;
      prev_sk = '0; prev_idx = '0;
      while (hs < 16 && cyc < 200) begin
         chk("valid_in_gen", subkey_valid, 1'b1);
         chk("busy_in_gen", busy, 1'b1);
         chk("round_idx", round_idx, hs);
         chk("subkey_model", subkey, ref_subkey(k, dec, hs));
         chk("key_err_clear", key_err, 1'b0);
         if (!prev_rdy) begin
            chk("hold_subkey", subkey, prev_sk);
            chk("hold_idx", round_idx, prev_idx);
         end
         if (hs < 16) got[hs] = subkey;
         case (mode)
            0:       rdy = 1;
            1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: rdy = $urandom_range(0, 1);
         endcase
         if (inject && hs == 5 && !injected) begin
            start = 1'b1; key = KEY_B; decrypt = ~dec; injected = 1;
         end
         subkey_ready = rdy;
         prev_sk = subkey; prev_idx = round_idx; prev_rdy = rdy;
         tick();
         start = 1'b0;
         if (rdy) hs++;
         cyc++;
      end
      chk("handshakes", hs, 16);
      if (mode == 0) chk("valid_cycles", cyc, 16);
      chk("done_pulse", done, 1'b1);
      chk("busy_at_done", busy, 1'b0);
      chk("valid_at_done", subkey_valid, 1'b0);
      subkey_ready = 1'b1;
      tick();
      chk("done_one_cycle", done, 1'b0);
      chk("idle_valid", subkey_valid, 1'b0);
      tick();
      chk("idle_ready_ignored", subkey_valid, 1'b0);
      chk("idle_busy", busy, 1'b0);
      subkey_ready = 1'b0;
   endtask

   typedef struct {
      logic [63:0] k;
      logic        dec;
      int          idx;
      logic [47:0] exp;
   } vec_t;

   vec_t tv [8];

   initial begin
      tv[0] = '{KEY_A, 1'b0,  0, 48'h1B02EFFC7072};
      tv[1] = '{KEY_A, 1'b0,  1, 48'h79AED9DBC9E5};
      tv[2] = '{KEY_A, 1'b0,  2, 48'h55FC8A42CF99};
      tv[3] = '{KEY_A, 1'b0, 15, 48'hCB3D8B0E17F5};
      tv[4] = '{KEY_A, 1'b1,  0, 48'hCB3D8B0E17F5};
      tv[5] = '{KEY_A, 1'b1, 13, 48'h55FC8A42CF99};
      tv[6] = '{KEY_A, 1'b1, 14, 48'h79AED9DBC9E5};
      tv[7] = '{KEY_A, 1'b1, 15, 48'h1B02EFFC7072};

      rst_n = 1'b0; start = 1'b0; key = '0; decrypt = 1'b0; subkey_ready = 1'b0;
      tick(); tick();
      chk("rst_subkey", subkey, 48'h0);
      chk("rst_valid", subkey_valid, 1'b0);
      chk("rst_idx", round_idx, 4'd0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_key_err", key_err, 1'b0);
      rst_n = 1'b1;
      tick();

      // Published example vectors.
      for (int i = 0; i < 8; i++) begin
         run_sched(tv[i].k, tv[i].dec, 0, 0);
         chk($sformatf("vec%0d", i), got[tv[i].idx], tv[i].exp);
      end

      // Backpressure and ignored start during GEN.
      run_sched(KEY_A, 1'b0, 1, 0);
      chk("bp_first", got[0], 48'h1B02EFFC7072);
      run_sched(KEY_A, 1'b1, 1, 0);
      run_sched(KEY_A, 1'b0, 0, 1);
      chk("inject_last", got[15], 48'hCB3D8B0E17F5);

      // Reset at round 8, then restart from K1.
      key = KEY_A; decrypt = 1'b0; start = 1'b1;
      tick();
      start = 1'b0; subkey_ready = 1'b1;
      repeat (8) tick();
      chk("mid_idx", round_idx, 4'd8);
      subkey_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("async_subkey", subkey, 48'h0);
      chk("async_valid", subkey_valid, 1'b0);
      chk("async_idx", round_idx, 4'd0);
      chk("async_busy", busy, 1'b0);
      chk("async_done", done, 1'b0);
      tick();
      rst_n = 1'b1;
      tick();
      run_sched(KEY_A, 1'b0, 0, 0);
      chk("restart_k1", got[0], 48'h1B02EFFC7072);

      // start held high: next schedule begins on the first IDLE cycle after DONE.
      key = KEY_A; decrypt = 1'b0; start = 1'b1; subkey_ready = 1'b1;
      tick();
      repeat (16) tick();
      chk("held_done", done, 1'b1);
      tick();
      chk("held_idle_busy", busy, 1'b0);
      tick();
      chk("held_restart_valid", subkey_valid, 1'b1);
      chk("held_restart_k1", subkey, 48'h1B02EFFC7072);
      start = 1'b0;
      repeat (16) tick();
      chk("held_done2", done, 1'b1);
      tick();

      // Parity feature.
      key = 64'h123457799BBCDFF1; decrypt = 1'b0; start = 1'b1; subkey_ready = 1'b1;
      tick();
      start = 1'b0;
`ifdef DES_KEY_PARITY_CHECK_EN
      chk("par_done", done, 1'b1);
      chk("par_err", key_err, 1'b1);
      chk("par_valid", subkey_valid, 1'b0);
      tick();
      chk("par_err_sticky", key_err, 1'b1);
      chk("par_no_valid", subkey_valid, 1'b0);
      tick();
`else
      chk("nopar_valid", subkey_valid, 1'b1);
      chk("nopar_err", key_err, 1'b0);
      chk("nopar_k1", subkey, ref_subkey(64'h123457799BBCDFF1, 1'b0, 0));
      repeat (16) tick();
      chk("nopar_done", done, 1'b1);
      tick();
`endif
      run_sched(KEY_A, 1'b0, 0, 0);

      // Randomized keys, directions and ready patterns.
      for (int r = 0; r < 8; r++) begin
         run_sched(fix_parity({$urandom, $urandom}), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 2)), 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
